// File: rtl/seg_pkg.sv
//------------------------------------------------------------------------------
// Module : seg_pkg
// Brief  : Shared constants, scan FSM states and hex-to-segment table for the
//          4-digit 7-segment display scanner.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Active-high segment patterns {g,f,e,d,c,b,a}, indexed by nibble value
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

`default_nettype wire

// File: rtl/seg_display_scan_if.sv
//------------------------------------------------------------------------------
// Module : seg_display_scan_if
// Brief  : Register-write and display-drive signals of the scanner.
//          The bright signal exists only when SEG_BRIGHTNESS_EN is defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seg_display_scan_if;
    import seg_pkg::*;

    logic                  data_wr;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0] dp_in;
    logic [NUM_DIGITS-1:0] en_in;
`ifdef SEG_BRIGHTNESS_EN
    logic [2:0]            bright;
`endif
    logic [7:0]            seg;
    logic [NUM_DIGITS-1:0] dig_sel;
    logic                  frame_done;

`ifdef SEG_BRIGHTNESS_EN
    modport master (output data_wr, data_in, dp_in, en_in, bright,
                    input  seg, dig_sel, frame_done);
    modport slave  (input  data_wr, data_in, dp_in, en_in, bright,
                    output seg, dig_sel, frame_done);
`else
    modport master (output data_wr, data_in, dp_in, en_in,
                    input  seg, dig_sel, frame_done);
    modport slave  (input  data_wr, data_in, dp_in, en_in,
                    output seg, dig_sel, frame_done);
`endif

endinterface

`default_nettype wire

// File: rtl/seg_hex_decode.sv
//------------------------------------------------------------------------------
// Module : seg_hex_decode
// Brief  : Combinational nibble to active-high 7-segment pattern lookup.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = HEX_SEG_TABLE[nibble];

endmodule

`default_nettype wire

// File: rtl/seg_display_scan.sv
//------------------------------------------------------------------------------
// Module : seg_display_scan
// Brief  : Time-multiplexed 4-digit 7-segment scanner with blanking dead time,
//          frame-aligned register updates and optional brightness (macro
//          SEG_BRIGHTNESS_EN adds the bright input and on-time limiting).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_display_scan
    import seg_pkg::*;
#(
    parameter int SLOT_CYC       = 50000,
    parameter int BLANK_CYC      = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    seg_display_scan_if.slave bus
);

    localparam int MAX_CYC = (SLOT_CYC > BLANK_CYC) ? SLOT_CYC : BLANK_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0]      SLOT_LAST  = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF    = DIG_ACTIVE_LOW ? '1 : '0;

    scan_state_t             state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [IDX_W-1:0]        idx, idx_next;
    logic                    slot_end, frame_start, lit;

    logic [4*NUM_DIGITS-1:0] pend_data, act_data;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp, pend_en, act_en;
    logic                    pend_flag;

    logic [6:0]              pattern;
    logic [7:0]              seg_raw, seg_q;
    logic [NUM_DIGITS-1:0]   dig_raw, dig_q;
    logic                    frame_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt + 1'b1;
        idx_next    = idx;
        slot_end    = 1'b0;
        frame_start = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_next  = ST_SHOW;
                    cnt_next    = '0;
                    frame_start = (idx == '0);
                end
            end
            ST_SHOW: begin
                if (cnt == SLOT_LAST) begin
                    state_next = ST_BLANK;
                    cnt_next   = '0;
                    idx_next   = idx + 1'b1;
                    slot_end   = 1'b1;
                end
            end
            default: begin
                state_next = ST_BLANK;
                cnt_next   = '0;
            end
        endcase
    end

    // A write landing on the boundary edge must survive the copy, so set wins over clear
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_en   <= '0;
            pend_flag <= 1'b0;
            act_data  <= '0;
            act_dp    <= '0;
            act_en    <= '0;
        end else begin
            if (frame_start && pend_flag) begin
                act_data <= pend_data;
                act_dp   <= pend_dp;
                act_en   <= pend_en;
            end
            if (bus.data_wr) begin
                pend_data <= bus.data_in;
                pend_dp   <= bus.dp_in;
                pend_en   <= bus.en_in;
                pend_flag <= 1'b1;
            end else if (frame_start) begin
                pend_flag <= 1'b0;
            end
        end
    end

`ifdef SEG_BRIGHTNESS_EN
    assign lit = (int'(cnt) < (int'(bus.bright) + 1) * (SLOT_CYC / 8));
`else
    assign lit = 1'b1;
`endif

    seg_hex_decode u_decode (
        .nibble  (act_data[{idx, 2'b00} +: 4]),
        .pattern (pattern)
    );

    always_comb begin
        seg_raw = 8'h00;
        dig_raw = '0;
        if (state == ST_SHOW && lit) begin
            seg_raw = {act_dp[idx], pattern};
            if (act_en[idx]) begin
                dig_raw = NUM_DIGITS'(1) << idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_raw ^ SEG_OFF;
            dig_q   <= dig_raw ^ DIG_OFF;
            frame_q <= slot_end && (idx == IDX_LAST);
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dig_sel    = dig_q;
    assign bus.frame_done = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_scan.sv
//------------------------------------------------------------------------------
// Module : tb_seg_display_scan
// Brief  : Self-checking bench for seg_display_scan (SLOT_CYC=16, BLANK_CYC=4,
//          active-low outputs); honours SEG_BRIGHTNESS_EN when defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg_display_scan;

    localparam int SLOT  = 16;
    localparam int BLANK = 4;
    localparam int SLOT_PERIOD  = SLOT + BLANK;
    localparam int FRAME_PERIOD = 4 * SLOT_PERIOD;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    seg_display_scan_if bus ();

    seg_display_scan #(
        .SLOT_CYC       (SLOT),
        .BLANK_CYC      (BLANK),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [6:0] hex_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference state: position within the frame plus the visible/pending register sets
    int          ph;
    logic [15:0] m_pend_data, m_act_data;
    logic [3:0]  m_pend_dp, m_act_dp, m_pend_en, m_act_en;
    bit          m_pflag;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_fd;
    int          cyc;
    int          last_fd;
    int          vectors;
    int          miscompares;

    function automatic bit model_lit(int show_cnt);
`ifdef SEG_BRIGHTNESS_EN
        return show_cnt < (int'(bus.bright) + 1) * (SLOT / 8);
`else
        return show_cnt >= 0;
`endif
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic step();
        int slot;
        int q;
        logic [3:0] nib;
        @(posedge clk);
        cyc++;
        if (!rstn) begin
            ph = 0;
            m_pend_data = '0; m_pend_dp = '0; m_pend_en = '0; m_pflag = 1'b0;
            m_act_data  = '0; m_act_dp  = '0; m_act_en  = '0;
            exp_seg = 8'hFF; exp_dig = 4'hF; exp_fd = 1'b0;
            last_fd = -1;
        end else begin
            slot = ph / SLOT_PERIOD;
            q    = ph % SLOT_PERIOD;
            exp_seg = 8'hFF;
            exp_dig = 4'hF;
            if (q >= BLANK && model_lit(q - BLANK)) begin
                nib = 4'((m_act_data >> (4 * slot)) & 16'hF);
                exp_seg = ~{m_act_dp[slot], hex_tbl[nib]};
                if (m_act_en[slot]) exp_dig = ~(4'b0001 << slot);
            end
            exp_fd = (ph == FRAME_PERIOD - 1);
            if (ph == BLANK - 1 && m_pflag) begin
                m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_en = m_pend_en;
                m_pflag = 1'b0;
            end
            if (bus.data_wr) begin
                m_pend_data = bus.data_in; m_pend_dp = bus.dp_in; m_pend_en = bus.en_in;
                m_pflag = 1'b1;
            end
            ph = (ph + 1) % FRAME_PERIOD;
        end
        #1;
        check("seg", bus.seg, exp_seg);
        check("dig_sel", {4'h0, bus.dig_sel}, {4'h0, exp_dig});
        check("frame_done", {7'h0, bus.frame_done}, {7'h0, exp_fd});
        if (bus.frame_done === 1'b1) begin
            if (last_fd >= 0) check("frame_period", 8'(cyc - last_fd), 8'(FRAME_PERIOD));
            last_fd = cyc;
        end
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic write(logic [15:0] d, logic [3:0] dp, logic [3:0] en);
        bus.data_wr = 1'b1;
        bus.data_in = d;
        bus.dp_in   = dp;
        bus.en_in   = en;
        step();
        bus.data_wr = 1'b0;
        bus.data_in = 16'($urandom);
    endtask

    task automatic wait_phase(int p);
        for (int i = 0; i < FRAME_PERIOD && ph != p; i++) step();
        vectors++;
        assert (ph == p) else begin
            miscompares++;
            $error("FAIL wait_phase observed=%0d expected=%0d", ph, p);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; last_fd = -1; ph = 0;
        rstn = 1'b0;
        bus.data_wr = 1'b0;
        bus.data_in = '0;
        bus.dp_in   = '0;
        bus.en_in   = '0;
`ifdef SEG_BRIGHTNESS_EN
        bus.bright  = 3'd7;
`endif
        run(3);
        rstn = 1'b1;

        step();
        write(16'($urandom), 4'($urandom), 4'($urandom));
        run(100);

        wait_phase(30);
        write(16'h1234, 4'h0, 4'hF);
        run(180);

        wait_phase(10);
        write(16'hAAAA, 4'($urandom), 4'hF);
        run(5);
        write(16'h00F0, 4'h0, 4'hF);
        run(160);

        wait_phase(50);
        write(16'($urandom), 4'h0, 4'b0101);
        run(170);

        write(16'h8000, 4'b1000, 4'hF);
        run(170);

        wait_phase(BLANK - 1);
        write(16'h5678, 4'($urandom), 4'hF);
        run(170);

        repeat (400) begin
            if ($urandom_range(0, 19) == 0)
                write(16'($urandom), 4'($urandom), 4'($urandom));
            else
                step();
`ifdef SEG_BRIGHTNESS_EN
            if ($urandom_range(0, 9) == 0) bus.bright = 3'($urandom);
`endif
        end

`ifdef SEG_BRIGHTNESS_EN
        bus.bright = 3'd1;
        run(FRAME_PERIOD * 2);
        bus.bright = 3'd7;
        run(FRAME_PERIOD);
`endif

        write(16'h9ABC, 4'hF, 4'hF);
        wait_phase(45);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        run(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
